exc_seq: RTL and testbench
==========================

EXC_SEQ -- requirements
Module: exc_seq

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of the saturating exception counter.
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: wb_valid  in  1  WB stage holds a valid instruction.
REQ-005 SHALL have port: wb_pc  in  32  PC of the WB instruction.
REQ-006 SHALL have port: wb_vaddr  in  32  load/store address of the WB instruction.
REQ-007 SHALL have port: wb_exc_vec  in  6  cause flags: [0]INT [1]ADEF [2]INE [3]SYS [4]BRK [5]ALE.
REQ-008 SHALL have port: wb_ertn  in  1  WB instruction is ertn.
REQ-009 SHALL have port: ex_entry  in  32  exception entry from CSR file.
REQ-010 SHALL have port: ertn_entry  in  32  return address from CSR file.
REQ-011 SHALL have port: wb_accept  out  1  sequencer can take a WB event this cycle.
REQ-012 SHALL have port: csr_wb_ex  out  1  one-cycle exception commit pulse to CSR file.
REQ-013 SHALL have port: csr_wb_ecode  out  6  exception code.
REQ-014 SHALL have port: csr_wb_esubcode  out  9  exception subcode.
REQ-015 SHALL have port: csr_wb_pc  out  32  faulting PC for ERA.
REQ-016 SHALL have port: csr_wb_vaddr  out  32  bad address for BADV.
REQ-017 SHALL have port: csr_ertn_flush  out  1  one-cycle ertn commit pulse to CSR file.
REQ-018 SHALL have port: pipe_flush  out  1  kill all younger pipeline stages.
REQ-019 SHALL have port: redirect_valid  out  1  fetch redirect request.
REQ-020 SHALL have port: redirect_pc  out  32  redirect target.
REQ-021 SHALL have port: redirect_ready  in  1  pre-IF accepts redirect.
REQ-022 SHALL have port: exc_count  out  CNT_W  saturating count of committed exceptions.

Function
REQ-023 SHALL implement FSM states IDLE, COMMIT, REDIRECT; wb_accept=1 only in IDLE.
REQ-024 IDLE: wb_valid and |wb_exc_vec SHALL latch cause, wb_pc, wb_vaddr, set kind=EXC, go COMMIT.
REQ-025 IDLE: wb_valid, wb_exc_vec==0, wb_ertn SHALL set kind=ERTN, go COMMIT; exception wins if both set.
REQ-026 IDLE: wb_valid low or no event SHALL stay IDLE; WB inputs SHALL be ignored outside IDLE.
REQ-027 Priority, highest first: INT, ADEF, INE, SYS, BRK, ALE; only the winner is encoded.
REQ-028 Encoding: INT 0x00, ADEF 0x08, ALE 0x09, SYS 0x0B, BRK 0x0C, INE 0x0D; esubcode 0 for all.
REQ-029 csr_wb_vaddr SHALL be latched wb_pc for ADEF, latched wb_vaddr otherwise.
REQ-030 COMMIT (exactly 1 cycle): csr_wb_ex=1 if EXC else csr_ertn_flush=1; pipe_flush=1; next REDIRECT.
REQ-031 csr_wb_ecode/esubcode/pc/vaddr SHALL be stable from COMMIT entry through REDIRECT exit.
REQ-032 On COMMIT->REDIRECT edge redirect_pc SHALL register ex_entry (EXC) or ertn_entry (ERTN).
REQ-033 REDIRECT: redirect_valid=1, pipe_flush=1, redirect_pc held; redirect_valid&redirect_ready -> IDLE.
REQ-034 redirect_valid SHALL NOT drop before acceptance; latency WB event to first redirect_valid = 2 cycles.
REQ-035 exc_count SHALL increment on each csr_wb_ex pulse, saturating at all-ones (no wrap).
REQ-036 csr_wb_ex and csr_ertn_flush SHALL never be asserted together.

Reset
REQ-037 reset SHALL asynchronously force IDLE, all outputs 0 except wb_accept=1, exc_count=0.
REQ-038 reset in COMMIT or REDIRECT SHALL abort the sequence; no pulse after reset deassertion.

Verification
REQ-039 ALE: wb_exc_vec=6'b100000, wb_vaddr=0x1003, ex_entry=0x1C008000 -> COMMIT ecode 0x09, vaddr 0x1003; redirect_pc 0x1C008000.
REQ-040 Priority: wb_exc_vec=6'b111111, wb_pc=0x100 -> ecode 0x00 only; exc_count 0->1.
REQ-041 ADEF with ertn: wb_exc_vec=6'b000010, wb_ertn=1, wb_pc=0x2 -> csr_wb_ex, vaddr 0x2, no csr_ertn_flush.
REQ-042 ertn: redirect_ready low 5 cycles, ertn_entry=0x1C000100 -> redirect_valid held 5+ cycles, pc stable, IDLE after accept.
REQ-043 Saturation: CNT_W=2, 5 exceptions -> exc_count 1,2,3,3,3.
REQ-044 Reset mid-REDIRECT -> immediately IDLE, redirect_valid=0, pipe_flush=0, exc_count=0.

Source files
------------

// File: rtl/exc_seq_if.sv
// rtl/exc_seq_if.sv - WB event, CSR commit and fetch redirect signals of the exception sequencer
interface exc_seq_if;
  // WB stage event
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic [5:0]  wb_exc_vec;
  logic        wb_ertn;
  logic        wb_accept;

  // CSR file side
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        csr_wb_ex;
  logic [5:0]  csr_wb_ecode;
  logic [8:0]  csr_wb_esubcode;
  logic [31:0] csr_wb_pc;
  logic [31:0] csr_wb_vaddr;
  logic        csr_ertn_flush;

  // pipeline kill and fetch redirect
  logic        pipe_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  // pipeline/CSR side
  modport master (
    output wb_valid, wb_pc, wb_vaddr, wb_exc_vec, wb_ertn,
    output ex_entry, ertn_entry, redirect_ready,
    input  wb_accept, csr_wb_ex, csr_wb_ecode, csr_wb_esubcode,
    input  csr_wb_pc, csr_wb_vaddr, csr_ertn_flush,
    input  pipe_flush, redirect_valid, redirect_pc
  );

  // sequencer side
  modport slave (
    input  wb_valid, wb_pc, wb_vaddr, wb_exc_vec, wb_ertn,
    input  ex_entry, ertn_entry, redirect_ready,
    output wb_accept, csr_wb_ex, csr_wb_ecode, csr_wb_esubcode,
    output csr_wb_pc, csr_wb_vaddr, csr_ertn_flush,
    output pipe_flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_seq.sv
// rtl/exc_seq.sv - exception / ertn commit sequencer: CSR commit pulse, pipeline flush, fetch redirect
module exc_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  exc_seq_if.slave         bus,
  output logic [CNT_W-1:0] exc_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_is_exc;
  logic [5:0]        r_ecode;
  logic [31:0]       r_pc;
  logic [31:0]       r_vaddr;
  logic [31:0]       r_redirect_pc;
  logic [CNT_W-1:0]  r_count;

  logic              w_event_exc;
  logic              w_event_ertn;
  logic              w_start;
  logic [5:0]        w_ecode;
  logic              w_adef_wins;

  logic              w_accept;
  logic              w_wb_ex;
  logic              w_ertn_flush;
  logic              w_pipe_flush;
  logic              w_redirect_valid;

  // an exception in WB always beats a concurrent ertn
  assign w_event_exc  = bus.wb_valid & (|bus.wb_exc_vec);
  assign w_event_ertn = bus.wb_valid & ~(|bus.wb_exc_vec) & bus.wb_ertn;
  assign w_start      = w_event_exc | w_event_ertn;

  // priority-encode the cause flags: INT > ADEF > INE > SYS > BRK > ALE
  always_comb begin
    w_ecode     = 6'h00;
    w_adef_wins = 1'b0;
    if (bus.wb_exc_vec[0]) begin
      w_ecode = 6'h00;
    end else if (bus.wb_exc_vec[1]) begin
      w_ecode     = 6'h08;
      w_adef_wins = 1'b1;
    end else if (bus.wb_exc_vec[2]) begin
      w_ecode = 6'h0D;
    end else if (bus.wb_exc_vec[3]) begin
      w_ecode = 6'h0B;
    end else if (bus.wb_exc_vec[4]) begin
      w_ecode = 6'h0C;
    end else if (bus.wb_exc_vec[5]) begin
      w_ecode = 6'h09;
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state and per-state outputs; WB inputs only matter in IDLE
  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = 1'b0;
    w_wb_ex          = 1'b0;
    w_ertn_flush     = 1'b0;
    w_pipe_flush     = 1'b0;
    w_redirect_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = 1'b1;
        if (w_start) begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_wb_ex      = r_is_exc;
        w_ertn_flush = ~r_is_exc;
        w_pipe_flush = 1'b1;
        w_state_nxt  = S_REDIRECT;
      end
      S_REDIRECT: begin
        w_pipe_flush     = 1'b1;
        w_redirect_valid = 1'b1;
        if (bus.redirect_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // capture the event kind and, for exceptions, the cause/PC/bad address; held until the next event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_exc <= 1'b0;
      r_ecode  <= 6'h00;
      r_pc     <= 32'h0;
      r_vaddr  <= 32'h0;
    end else if (r_state == S_IDLE && w_start) begin
      r_is_exc <= w_event_exc;
      if (w_event_exc) begin
        r_ecode <= w_ecode;
        r_pc    <= bus.wb_pc;
        r_vaddr <= w_adef_wins ? bus.wb_pc : bus.wb_vaddr;
      end
    end
  end

  // redirect target is sampled from the CSR file as COMMIT hands over to REDIRECT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_redirect_pc <= 32'h0;
    end else if (r_state == S_COMMIT) begin
      r_redirect_pc <= r_is_exc ? bus.ex_entry : bus.ertn_entry;
    end
  end

  // count committed exceptions, sticking at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_wb_ex && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign bus.wb_accept       = w_accept;
  assign bus.csr_wb_ex       = w_wb_ex;
  assign bus.csr_ertn_flush  = w_ertn_flush;
  assign bus.csr_wb_ecode    = r_ecode;
  assign bus.csr_wb_esubcode = 9'h000;
  assign bus.csr_wb_pc       = r_pc;
  assign bus.csr_wb_vaddr    = r_vaddr;
  assign bus.pipe_flush      = w_pipe_flush;
  assign bus.redirect_valid  = w_redirect_valid;
  assign bus.redirect_pc     = r_redirect_pc;
  assign exc_count           = r_count;

endmodule

// File: tb/tb_exc_seq.sv
// tb/tb_exc_seq.sv - self-checking bench for exc_seq with a behavioural model
module tb_exc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cnt_big;
  logic [1:0]  cnt_small;

  always #5 clk = ~clk;

  exc_seq_if if0();
  exc_seq_if if1();

  exc_seq #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (if0.slave),
    .exc_count (cnt_big)
  );

  exc_seq #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .bus       (if1.slave),
    .exc_count (cnt_small)
  );

  assign if1.wb_valid       = if0.wb_valid;
  assign if1.wb_pc          = if0.wb_pc;
  assign if1.wb_vaddr       = if0.wb_vaddr;
  assign if1.wb_exc_vec     = if0.wb_exc_vec;
  assign if1.wb_ertn        = if0.wb_ertn;
  assign if1.ex_entry       = if0.ex_entry;
  assign if1.ertn_entry     = if0.ertn_entry;
  assign if1.redirect_ready = if0.redirect_ready;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Lowest set flag index is the highest-priority cause.
  function automatic int winner(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [5:0] code_of(input int w);
    case (w)
      0: return 6'h00;  // INT
      1: return 6'h08;  // ADEF
      2: return 6'h0D;  // INE
      3: return 6'h0B;  // SYS
      4: return 6'h0C;  // BRK
      5: return 6'h09;  // ALE
      default: return 6'h3F;
    endcase
  endfunction

  // m_busy: an event is being sequenced; m_age: cycles since it was taken (1 = commit cycle)
  bit          m_busy;
  int          m_age;
  bit          m_exc;
  logic [5:0]  m_ecode;
  logic [31:0] m_pc, m_vaddr, m_rpc;
  int          m_cnt_big, m_cnt_small;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_age <= 0; m_exc <= 0;
      m_ecode <= 6'h0; m_pc <= 32'h0; m_vaddr <= 32'h0; m_rpc <= 32'h0;
      m_cnt_big <= 0; m_cnt_small <= 0;
    end else if (m_busy) begin
      if (m_age == 1) begin
        if (m_exc) begin
          m_cnt_big   <= (m_cnt_big   < 65535) ? m_cnt_big + 1   : m_cnt_big;
          m_cnt_small <= (m_cnt_small < 3)     ? m_cnt_small + 1 : m_cnt_small;
        end
        m_rpc <= m_exc ? if0.ex_entry : if0.ertn_entry;
        m_age <= 2;
      end else if (if0.redirect_ready) begin
        m_busy <= 0;
      end
    end else if (if0.wb_valid && (if0.wb_exc_vec != 6'h0 || if0.wb_ertn)) begin
      m_busy <= 1;
      m_age  <= 1;
      m_exc  <= (if0.wb_exc_vec != 6'h0);
      if (if0.wb_exc_vec != 6'h0) begin
        m_ecode <= code_of(winner(if0.wb_exc_vec));
        m_pc    <= if0.wb_pc;
        m_vaddr <= (winner(if0.wb_exc_vec) == 1) ? if0.wb_pc : if0.wb_vaddr;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("accept",      if0.wb_accept,       !m_busy);
      chk("wb_ex",       if0.csr_wb_ex,       m_busy && m_age == 1 && m_exc);
      chk("ertn_flush",  if0.csr_ertn_flush,  m_busy && m_age == 1 && !m_exc);
      chk("pipe_flush",  if0.pipe_flush,      m_busy);
      chk("rvalid",      if0.redirect_valid,  m_busy && m_age >= 2);
      chk("rpc",         if0.redirect_pc,     m_rpc);
      chk("ecode",       if0.csr_wb_ecode,    m_ecode);
      chk("esubcode",    if0.csr_wb_esubcode, 32'h0);
      chk("era_pc",      if0.csr_wb_pc,       m_pc);
      chk("badv",        if0.csr_wb_vaddr,    m_vaddr);
      chk("cnt16",       cnt_big,             m_cnt_big);
      chk("cnt2",        cnt_small,           m_cnt_small);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    if0.wb_valid = 0; if0.wb_pc = 0; if0.wb_vaddr = 0; if0.wb_exc_vec = 0;
    if0.wb_ertn = 0; if0.ex_entry = 0; if0.ertn_entry = 0; if0.redirect_ready = 0;
  endtask

  // One directed event with hand-computed expectations.
  task automatic run_evt(input string nm, input logic [5:0] vec, input logic ertn,
                         input logic [31:0] pc, input logic [31:0] vaddr, input logic [31:0] entry,
                         input logic exp_ex, input logic [5:0] exp_code, input logic [31:0] exp_vaddr,
                         input int hold_cycles, input logic [1:0] exp_small);
    @(negedge clk);
    if0.wb_valid = 1; if0.wb_exc_vec = vec; if0.wb_ertn = ertn;
    if0.wb_pc = pc; if0.wb_vaddr = vaddr; if0.redirect_ready = 0;
    if0.ex_entry   = exp_ex ? entry : ~entry;
    if0.ertn_entry = exp_ex ? ~entry : entry;
    @(negedge clk);
    if0.wb_valid = 0; if0.wb_exc_vec = 0; if0.wb_ertn = 0;
    chk({nm, "_ex"},    if0.csr_wb_ex,      exp_ex);
    chk({nm, "_ertn"},  if0.csr_ertn_flush, !exp_ex);
    chk({nm, "_flush"}, if0.pipe_flush,     1);
    if (exp_ex) begin
      chk({nm, "_ecode"}, if0.csr_wb_ecode, exp_code);
      chk({nm, "_badv"},  if0.csr_wb_vaddr, exp_vaddr);
      chk({nm, "_era"},   if0.csr_wb_pc,    pc);
    end
    @(negedge clk);
    chk({nm, "_rv"},    if0.redirect_valid, 1);
    chk({nm, "_rpc"},   if0.redirect_pc,    entry);
    chk({nm, "_cnt2"},  cnt_small,          exp_small);
    for (int k = 0; k < hold_cycles; k++) begin
      @(negedge clk);
      chk({nm, "_rv_hold"},  if0.redirect_valid, 1);
      chk({nm, "_rpc_hold"}, if0.redirect_pc,    entry);
    end
    if0.redirect_ready = 1;
    @(negedge clk);
    if0.redirect_ready = 0;
    chk({nm, "_idle"}, if0.wb_accept,      1);
    chk({nm, "_rv0"},  if0.redirect_valid, 0);
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_accept", if0.wb_accept,      1);
    chk("rst_ex",     if0.csr_wb_ex,      0);
    chk("rst_ertn",   if0.csr_ertn_flush, 0);
    chk("rst_flush",  if0.pipe_flush,     0);
    chk("rst_rv",     if0.redirect_valid, 0);
    chk("rst_rpc",    if0.redirect_pc,    0);
    chk("rst_cnt",    cnt_big,            0);
    @(negedge clk);
    #2 reset = 0;

    run_evt("prio", 6'b111111, 0, 32'h100,  32'h55,   32'h1C008000, 1, 6'h00, 32'h55,   0, 2'd1);
    chk("prio_cnt16", cnt_big, 1);
    run_evt("ale",  6'b100000, 0, 32'h400,  32'h1003, 32'h1C008000, 1, 6'h09, 32'h1003, 0, 2'd2);
    run_evt("adef", 6'b000010, 1, 32'h2,    32'h77,   32'h1C008000, 1, 6'h08, 32'h2,    0, 2'd3);
    run_evt("ertn", 6'b000000, 1, 32'h800,  32'h99,   32'h1C000100, 0, 6'h00, 32'h0,    5, 2'd3);
    run_evt("brk",  6'b010000, 0, 32'h900,  32'hAB,   32'h1C008000, 1, 6'h0C, 32'hAB,   0, 2'd3);
    run_evt("sys",  6'b011000, 0, 32'hA00,  32'hCD,   32'h1C008000, 1, 6'h0B, 32'hCD,   1, 2'd3);
    run_evt("ine",  6'b100100, 0, 32'hB00,  32'hEF,   32'h1C008000, 1, 6'h0D, 32'hEF,   0, 2'd3);
    chk("cnt16_six", cnt_big, 6);

    // abort in REDIRECT
    @(negedge clk);
    if0.wb_valid = 1; if0.wb_exc_vec = 6'b100000; if0.ex_entry = 32'h1C008000;
    @(negedge clk);
    if0.wb_valid = 0; if0.wb_exc_vec = 0;
    @(negedge clk);
    chk("abort_pre_rv", if0.redirect_valid, 1);
    #2 reset = 1;
    #1;
    chk("abort_rv",     if0.redirect_valid, 0);
    chk("abort_flush",  if0.pipe_flush,     0);
    chk("abort_cnt",    cnt_big,            0);
    chk("abort_cnt2",   cnt_small,          0);
    chk("abort_accept", if0.wb_accept,      1);
    @(negedge clk);
    #2 reset = 0;
    repeat (4) @(negedge clk);

    // randomized traffic, occasional asynchronous reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1;
        #1 chk("rnd_rst_accept", if0.wb_accept, 1);
        chk("rnd_rst_flush", if0.pipe_flush, 0);
        @(negedge clk);
        #2 reset = 0;
      end else begin
        if0.wb_valid = ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 3))
          0:       if0.wb_exc_vec = 6'h0;
          1:       if0.wb_exc_vec = 6'(1 << $urandom_range(0, 5));
          default: if0.wb_exc_vec = 6'($urandom);
        endcase
        if0.wb_ertn        = ($urandom_range(0, 1) == 1);
        if0.wb_pc          = $urandom;
        if0.wb_vaddr       = $urandom;
        if0.ex_entry       = $urandom;
        if0.ertn_entry     = $urandom;
        if0.redirect_ready = ($urandom_range(0, 9) < 3);
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
